data_mem_arbiter: RTL

- Shares the single DATA_MEM port between two requesters:
  - M0: the RISC_V core's data port.
  - M1: a loader/debug master that preloads and inspects data memory during simulation and bring-up.
- Performs at most one access per cycle.
- Uses round-robin priority with a bounded burst length, so neither master starves.
- Sits between the masters and DATA_MEM in the top-level and testbench.

---
 rtl/data_mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one DATA_MEM port between two masters (M0: core data port, M1: loader/debug).
// Round-robin with a bounded burst: an owner keeps the port for at most MAX_BURST
// consecutive grants while the other master is requesting. At most one access per cycle.
// The memory has 1-cycle read latency, so read data returns to the master that issued
// the read one cycle after its grant.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_mN_req/we/addr/wdata  master N request (held until granted), 1=write, address, data
//   o_mN_gnt                master N access accepted this cycle
//   o_mN_rdata/rvalid       master N read data and its valid strobe (rdata 0 when not valid)
//   o_mem_addr/data_in      address / write data to DATA_MEM (0 when no grant)
//   i_mem_data_out          read data from DATA_MEM (1-cycle latency)
//   o_mem_wr_en/rd_en       memory write / read enables
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_rvalid,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_rvalid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out,
  output logic              o_mem_wr_en,
  output logic              o_mem_rd_en
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} owner_e;

  owner_e              r_owner, w_owner_nxt;
  logic [BCNT_W-1:0]   r_bcnt, w_bcnt_nxt;
  logic                r_last, w_last_nxt;
  logic                r_rd_pend;
  logic                r_rd_id;

  logic                w_gnt0, w_gnt1;
  logic                w_arb0, w_arb1;
  logic                w_burst_ok;

  assign w_burst_ok = (r_bcnt < BCNT_MAX);

  // Grant decision from current state and requests.
  always_comb begin
    w_arb0 = 1'b0;
    w_arb1 = 1'b0;
    case (r_owner)
      StIdle: begin
        if (i_m0_req && i_m1_req) begin
          // Tie: the master that was not granted last wins.
          w_arb0 = r_last;
          w_arb1 = ~r_last;
        end else begin
          w_arb0 = i_m0_req;
          w_arb1 = i_m1_req;
        end
      end
      StOwn0: begin
        if (i_m0_req && (!i_m1_req || w_burst_ok)) w_arb0 = 1'b1;
        else if (i_m1_req)                         w_arb1 = 1'b1;
      end
      StOwn1: begin
        if (i_m1_req && (!i_m0_req || w_burst_ok)) w_arb1 = 1'b1;
        else if (i_m0_req)                         w_arb0 = 1'b1;
      end
      default: begin
        w_arb0 = 1'b0;
        w_arb1 = 1'b0;
      end
    endcase
  end

  // Reset forces the port quiet immediately, even with requests pending.
  assign w_gnt0 = w_arb0 & ~i_rst;
  assign w_gnt1 = w_arb1 & ~i_rst;

  // Next-state for owner, burst counter and last-granted master.
  always_comb begin
    w_owner_nxt = StIdle;
    w_bcnt_nxt  = '0;
    w_last_nxt  = r_last;
    if (w_gnt0) begin
      w_owner_nxt = StOwn0;
      w_last_nxt  = 1'b0;
      if (r_owner == StOwn0) w_bcnt_nxt = (r_bcnt == BCNT_MAX) ? r_bcnt : r_bcnt + BCNT_ONE;
      else                   w_bcnt_nxt = BCNT_ONE;
    end else if (w_gnt1) begin
      w_owner_nxt = StOwn1;
      w_last_nxt  = 1'b1;
      if (r_owner == StOwn1) w_bcnt_nxt = (r_bcnt == BCNT_MAX) ? r_bcnt : r_bcnt + BCNT_ONE;
      else                   w_bcnt_nxt = BCNT_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner   <= StIdle;
      r_bcnt    <= '0;
      r_last    <= 1'b1;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
    end else begin
      r_owner   <= w_owner_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_last    <= w_last_nxt;
      r_rd_pend <= (w_gnt0 & ~i_m0_we) | (w_gnt1 & ~i_m1_we);
      r_rd_id   <= w_gnt1;
    end
  end

  // Memory port mux.
  always_comb begin
    o_mem_addr    = '0;
    o_mem_data_in = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_rd_en   = 1'b0;
    if (w_gnt0) begin
      o_mem_addr    = i_m0_addr;
      o_mem_data_in = i_m0_wdata;
      o_mem_wr_en   = i_m0_we;
      o_mem_rd_en   = ~i_m0_we;
    end else if (w_gnt1) begin
      o_mem_addr    = i_m1_addr;
      o_mem_data_in = i_m1_wdata;
      o_mem_wr_en   = i_m1_we;
      o_mem_rd_en   = ~i_m1_we;
    end
  end

  assign o_m0_gnt = w_gnt0;
  assign o_m1_gnt = w_gnt1;

  // Read return routed to whichever master issued last cycle's read.
  assign o_m0_rvalid = r_rd_pend & ~r_rd_id & ~i_rst;
  assign o_m1_rvalid = r_rd_pend & r_rd_id & ~i_rst;
  assign o_m0_rdata  = o_m0_rvalid ? i_mem_data_out : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_mem_data_out : '0;

endmodule
